// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-channel memory controller and its arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_ctrl_pkg;

    // Package-level defaults; the controller itself is parametrised and
    // rebuilds its own widths from its parameters.
    localparam int DFLT_DATA_WIDTH = 32;
    localparam int DFLT_NUM_CH     = 4;
    localparam int BE_WIDTH        = DFLT_DATA_WIDTH / 8;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DFLT_CH_W = ch_idx_w(DFLT_NUM_CH);

    typedef struct packed {
        logic                       valid;
        logic [DFLT_CH_W-1:0]       ch;
        logic                       wr;
        logic                       err;
        logic [DFLT_DATA_WIDTH-1:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index, search starts at an internal pointer.
// Latency: grant is combinational from i_req; pointer moves on the edge where i_advance is high.
// Backpressure: pointer holds while i_advance is low or nothing is requested.
// Ports: clk/rst_n; i_req (request vector), i_advance (grant taken);
//        o_gnt (one-hot grant), o_idx (granted channel index).
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // Walk channels from r_ptr upward, wrapping; the first requester wins.
    always_comb begin
        int c;
        c       = 0;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            c = int'(r_ptr) + off;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!w_found && i_req[c[IDX_W-1:0]]) begin
                w_found = 1'b1;
                o_gnt   = NUM_CH'(1) << c;
                o_idx   = IDX_W'(c);
            end
        end
    end

    // Pointer moves to the channel just after the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (o_idx == IDX_W'(NUM_CH - 1)) ? '0 : o_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_ctrl_mc.sv
// Multi-channel memory controller: round-robin onto one single-port memory, byte-enabled writes.
// Latency: response visible RD_LATENCY cycles after accept, in accept order, one per request.
// Backpressure: one grant per cycle to a valid channel; the response side cannot stall.
// Ports: clk/rst_n; req_* per-channel request bundle with req_ready grant;
//        rsp_* single response stream (valid, channel, write-ack, error, read data).
module mem_ctrl_mc
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int NUM_CH     = 4,
    parameter int RD_LATENCY = 2,
    localparam int CH_W      = ch_idx_w(NUM_CH),
    localparam int BE_W      = DATA_WIDTH / 8,
    localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CH-1:0]                   req_valid,
    output logic [NUM_CH-1:0]                   req_ready,
    input  logic [NUM_CH-1:0]                   req_wr,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_CH-1:0][BE_W-1:0]         req_be,
    output logic                                rsp_valid,
    output logic [CH_W-1:0]                     rsp_ch,
    output logic                                rsp_wr,
    output logic [DATA_WIDTH-1:0]               rsp_data,
    output logic                                rsp_err
);

    typedef struct packed {
        logic                  valid;
        logic [CH_W-1:0]       ch;
        logic                  wr;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [NUM_CH-1:0]     w_gnt;
    logic [CH_W-1:0]       w_idx;
    logic                  w_acc;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_W-1:0]       w_be;
    logic                  w_in_range;
    logic [MEM_AW-1:0]     w_maddr;
    rsp_t                  w_new;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    rsp_t                  r_pipe [RD_LATENCY];

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req_valid),
        .i_advance (w_acc),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx)
    );

    // Grants are suppressed while reset is asserted so nothing is accepted then.
    assign req_ready = rst_n ? w_gnt : '0;
    assign w_acc     = |req_ready;

    assign w_wr    = req_wr[w_idx];
    assign w_addr  = req_addr[w_idx];
    assign w_wdata = req_wdata[w_idx];
    assign w_be    = req_be[w_idx];

    // One extra bit keeps the compare correct when DEPTH == 2**ADDR_WIDTH.
    assign w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign w_maddr    = w_addr[MEM_AW-1:0];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_acc && w_wr && w_in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (w_be[k]) begin
                    r_mem[w_maddr][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response for this cycle's accept; read data is the word before any
    // write on this same edge (only one request is accepted per edge).
    always_comb begin
        w_new = '0;
        if (w_acc) begin
            w_new.valid = 1'b1;
            w_new.ch    = w_idx;
            w_new.wr    = w_wr;
            w_new.err   = !w_in_range;
            if (!w_wr && w_in_range) begin
                w_new.data = r_mem[w_maddr];
            end
        end
    end

    // Idle stages carry all-zero entries, so outputs are zero when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= w_new;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign rsp_valid = r_pipe[RD_LATENCY-1].valid;
    assign rsp_ch    = r_pipe[RD_LATENCY-1].ch;
    assign rsp_wr    = r_pipe[RD_LATENCY-1].wr;
    assign rsp_err   = r_pipe[RD_LATENCY-1].err;
    assign rsp_data  = r_pipe[RD_LATENCY-1].data;

endmodule

// File: tb/tb_mem_ctrl_mc.sv
// Bench for mem_ctrl_mc: directed scenarios plus random traffic against a queue/array model.
// Latency: model expects each response LAT cycles after its accept edge.
// Backpressure: requests held on the ports until the model-predicted grant.
module tb_mem_ctrl_mc;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int CW    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NCH-1:0]           req_valid;
    logic [NCH-1:0]           req_ready;
    logic [NCH-1:0]           req_wr;
    logic [NCH-1:0][AW-1:0]   req_addr;
    logic [NCH-1:0][DW-1:0]   req_wdata;
    logic [NCH-1:0][DW/8-1:0] req_be;
    logic                     rsp_valid;
    logic [CW-1:0]            rsp_ch;
    logic                     rsp_wr;
    logic [DW-1:0]            rsp_data;
    logic                     rsp_err;

    always #5 clk = ~clk;

    mem_ctrl_mc #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .NUM_CH     (NCH),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_wr    (rsp_wr),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        int          due;
        int          ch;
        bit          wr;
        bit          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    int            gnt_log[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr   = 0;
    int            cyc     = 0;
    int            n_cmp   = 0;
    int            n_bad   = 0;
    logic [DW-1:0] last_rd = '0;
    logic          last_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            chk("rsp_late", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_ch",    rsp_ch,    e.ch);
            chk("rsp_wr",    rsp_wr,    e.wr);
            chk("rsp_err",   rsp_err,   e.err);
            chk("rsp_data",  rsp_data,  e.data);
            last_rd  = rsp_data;
            last_err = rsp_err;
        end else begin
            chk("rsp_idle", {rsp_valid, rsp_ch, rsp_wr, rsp_err, rsp_data}, '0);
        end
    endtask

    // Called at a falling edge with the request ports already set.
    task automatic step();
        int             g;
        int             a;
        logic [NCH-1:0] er;
        exp_t           e;
        #1;
        g = -1;
        for (int o = 0; o < NCH; o++) begin
            if (g < 0 && req_valid[(m_ptr + o) % NCH]) g = (m_ptr + o) % NCH;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        if (g >= 0) begin
            a      = int'(req_addr[g]);
            e.due  = cyc + LAT;
            e.ch   = g;
            e.wr   = req_wr[g];
            e.err  = (a >= DEPTH);
            e.data = '0;
            if (!e.err && !e.wr) e.data = m_mem[a];
            if (!e.err && e.wr) begin
                for (int k = 0; k < DW/8; k++) begin
                    if (req_be[g][k]) m_mem[a][8*k +: 8] = req_wdata[g][8*k +: 8];
                end
            end
            q.push_back(e);
            gnt_log.push_back(g);
            m_ptr = (g + 1) % NCH;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
        check_rsp();
        @(negedge clk);
    endtask

    task automatic issue(input int ch, input bit wr, input int addr,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        req_valid[ch] = 1'b1;
        req_wr[ch]    = wr;
        req_addr[ch]  = AW'(addr);
        req_wdata[ch] = d;
        req_be[ch]    = be;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic load_ch(input int c, input int max_addr);
        req_valid[c] = 1'b1;
        req_wr[c]    = 1'($urandom_range(0, 1));
        req_addr[c]  = AW'($urandom_range(0, max_addr));
        req_wdata[c] = $urandom;
        req_be[c]    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_ch, rsp_wr, rsp_err, rsp_data}, '0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value.
        for (int a = 0; a < DEPTH; a++) issue(0, 1'b1, a, $urandom, 4'hF);
        idle(LAT);

        // Single write then read on channel 0.
        issue(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 5, '0, '0);
        idle(LAT);
        chk("rd_addr5", last_rd, 32'hDEADBEEF);

        // Byte-enable merge, then an all-zero enable write that changes nothing.
        issue(0, 1'b1, 7, 32'h11223344, 4'hF);
        issue(0, 1'b1, 7, 32'hAABBCCDD, 4'b0101);
        issue(0, 1'b0, 7, '0, '0);
        idle(LAT);
        chk("be_merge", last_rd, 32'h11BB33DD);
        issue(0, 1'b1, 7, 32'hFFFFFFFF, 4'h0);
        issue(0, 1'b0, 7, '0, '0);
        idle(LAT);
        chk("be_zero", last_rd, 32'h11BB33DD);

        // Out of range read and write; word 0 must not be aliased by address 256.
        issue(1, 1'b0, 300, '0, '0);
        idle(LAT);
        chk("oor_err", last_err, 1);
        issue(2, 1'b1, 256, 32'hCAFEF00D, 4'hF);
        issue(3, 1'b0, 0, '0, '0);
        idle(LAT);

        // Read-after-write on consecutive edges.
        issue(0, 1'b1, 9, 32'h5A5A5A5A, 4'hF);
        issue(0, 1'b0, 9, '0, '0);
        idle(LAT);
        chk("raw", last_rd, 32'h5A5A5A5A);

        // Reset while two reads are in flight: their responses must vanish.
        issue(0, 1'b0, 1, '0, '0);
        issue(1, 1'b0, 2, '0, '0);
        rst_n = 1'b0;
        q.delete();
        m_ptr = 0;
        req_valid = '1;
        repeat (LAT + 1) begin
            #1;
            chk("midrst_valid", rsp_valid, 0);
            chk("midrst_ready", req_ready, 0);
            @(negedge clk);
        end
        req_valid = '0;
        rst_n = 1'b1;
        idle(LAT + 1);

        // Fairness: all channels request continuously for 8 grants.
        gnt_log.delete();
        for (int c = 0; c < NCH; c++) load_ch(c, DEPTH - 1);
        for (int i = 0; i < 8; i++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                if (!req_valid[c]) load_ch(c, DEPTH - 1);
            end
        end
        req_valid = '0;
        for (int i = 0; i < 8; i++) chk("fair_gnt", gnt_log[i], i % NCH);
        idle(LAT);

        // Random traffic, including out-of-range addresses.
        repeat (600) begin
            for (int c = 0; c < NCH; c++) begin
                if (!req_valid[c] && $urandom_range(0, 1) == 1) load_ch(c, 299);
            end
            step();
        end
        req_valid = '0;
        idle(LAT + 1);
        chk("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
